regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-read-port register file.
//   master : writeback strobe/index/data, reserve strobe/index, per-port
//            read enables and packed read indices; receives packed read
//            data and per-port busy bits.
//   slave  : the register file side of the same signals.
// Read port i uses read_sel[i*AW +: AW], data_out[i*XLEN +: XLEN] and
// busy_out[i].
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(NREGS);

   logic                  write_en;
   logic [AW-1:0]         write_sel;
   logic [XLEN-1:0]       data_in;
   logic                  rsv_en;
   logic [AW-1:0]         rsv_sel;
   logic [NREAD-1:0]      read_en;
   logic [NREAD*AW-1:0]   read_sel;
   logic [NREAD*XLEN-1:0] data_out;
   logic [NREAD-1:0]      busy_out;

   modport master (
      output write_en, write_sel, data_in, rsv_en, rsv_sel, read_en, read_sel,
      input  data_out, busy_out
   );

   modport slave (
      input  write_en, write_sel, data_in, rsv_en, rsv_sel, read_en, read_sel,
      output data_out, busy_out
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NREAD synchronous write-first
// read ports, optional hardwired zero register and a per-register busy bit
// used by issue to detect RAW hazards.
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset, clears every register, busy bit
//           and registered output
//   bus   : regfile_mp_if slave modport (writeback, reserve, read ports)
// Read data and busy bits are registered (1-cycle latency) and hold while a
// port's read enable is low.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_mp_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]       regs_q [NREGS];
   logic [XLEN-1:0]       regs_d [NREGS];
   logic [NREGS-1:0]      busy_q, busy_d;
   logic [NREAD*XLEN-1:0] data_q, data_d;
   logic [NREAD-1:0]      bsy_q,  bsy_d;
   logic                  wr_ok, rsv_ok;

   // With a hardwired zero register, index 0 never accepts a write or a
   // reservation, so it stays at its reset value of 0 data / not busy and
   // reads of it (forwarded or not) naturally return zero.
   assign wr_ok  = bus.write_en && !((ZERO_REG != 0) && (bus.write_sel == '0));
   assign rsv_ok = bus.rsv_en   && !((ZERO_REG != 0) && (bus.rsv_sel   == '0));

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      data_d = data_q;
      bsy_d  = bsy_q;
      if (wr_ok) begin
         regs_d[bus.write_sel] = bus.data_in;
         busy_d[bus.write_sel] = 1'b0;
      end
      // Reserve is applied after the writeback clear: a newly issued
      // producer keeps the register busy even if an older one completes now.
      if (rsv_ok) begin
         busy_d[bus.rsv_sel] = 1'b1;
      end
      // Reads sample the post-edge state, which gives write-first
      // forwarding of both data and busy without a separate bypass mux.
      for (int i = 0; i < NREAD; i++) begin
         if (bus.read_en[i]) begin
            data_d[i*XLEN +: XLEN] = regs_d[bus.read_sel[i*AW +: AW]];
            bsy_d[i]               = busy_d[bus.read_sel[i*AW +: AW]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
         data_q <= '0;
         bsy_q  <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q <= busy_d;
         data_q <= data_d;
         bsy_q  <= bsy_d;
      end
   end

   assign bus.data_out = data_q;
   assign bus.busy_out = bsy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share clock and reset.
//   A: XLEN=32, NREGS=32, NREAD=2, ZERO_REG=1
//   B: XLEN=64, NREGS=16, NREAD=3, ZERO_REG=0
// Stimulus updates an array-based reference model and queues the expected
// output of every port for the coming edge; a monitor pops and compares on
// the following negedge.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_probe = 1'b0;
   int   ecnt = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) ifa ();
   regfile_mp_if #(.XLEN(64), .NREGS(16), .NREAD(3)) ifb ();

   regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   typedef struct packed {
      logic            we;
      logic [4:0]      wsel;
      logic [63:0]     din;
      logic            rsv;
      logic [4:0]      rsel;
      logic [2:0]      ren;
      logic [2:0][4:0] rdsel;
   } stim_t;

   typedef struct packed {
      int          tag;
      logic [1:0]  inst;
      logic [1:0]  port;
      logic [63:0] d;
      logic        b;
   } exp_t;

   exp_t q[$];

   // Reference model: architectural registers, busy bits and what each
   // read port currently shows.
   logic [63:0] m_regs [2][32];
   logic        m_busy [2][32];
   logic [63:0] m_dout [2][3];
   logic        m_bout [2][3];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[k][r] = '0;
            m_busy[k][r] = 1'b0;
         end
         for (int p = 0; p < 3; p++) begin
            m_dout[k][p] = '0;
            m_bout[k][p] = 1'b0;
         end
      end
   endtask

   task automatic model_step(input int k, input stim_t s);
      int          np;
      bit          zr;
      logic [63:0] mask;
      np   = (k == 0) ? 2 : 3;
      zr   = (k == 0);
      mask = (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      if (s.we && !(zr && s.wsel == 5'd0)) begin
         m_regs[k][s.wsel] = s.din & mask;
         m_busy[k][s.wsel] = 1'b0;
      end
      if (s.rsv && !(zr && s.rsel == 5'd0)) m_busy[k][s.rsel] = 1'b1;
      for (int p = 0; p < np; p++) begin
         if (s.ren[p]) begin
            m_dout[k][p] = m_regs[k][s.rdsel[p]];
            m_bout[k][p] = m_busy[k][s.rdsel[p]];
         end
         q.push_back('{tag: ecnt + 1, inst: 2'(k), port: 2'(p),
                       d: m_dout[k][p], b: m_bout[k][p]});
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rnd(input int nr);
      stim_t s;
      s.we   = 1'($urandom_range(0, 1));
      s.wsel = 5'($urandom % nr);
      s.din  = {$urandom, $urandom};
      s.rsv  = ($urandom % 3 == 0);
      s.rsel = ($urandom % 4 == 0) ? s.wsel : 5'($urandom % nr);
      s.ren  = 3'($urandom);
      for (int p = 0; p < 3; p++)
         s.rdsel[p] = ($urandom % 4 == 0) ? s.wsel : 5'($urandom % nr);
      return s;
   endfunction

   // Drives both instances for one edge, returns 1 time unit after it.
   task automatic cycle(input stim_t sa, input stim_t sb);
      ifa.write_en  = sa.we;
      ifa.write_sel = sa.wsel;
      ifa.data_in   = sa.din[31:0];
      ifa.rsv_en    = sa.rsv;
      ifa.rsv_sel   = sa.rsel;
      ifa.read_en   = sa.ren[1:0];
      for (int p = 0; p < 2; p++) ifa.read_sel[p*5 +: 5] = sa.rdsel[p];
      ifb.write_en  = sb.we;
      ifb.write_sel = sb.wsel[3:0];
      ifb.data_in   = sb.din;
      ifb.rsv_en    = sb.rsv;
      ifb.rsv_sel   = sb.rsel[3:0];
      ifb.read_en   = sb.ren;
      for (int p = 0; p < 3; p++) ifb.read_sel[p*4 +: 4] = sb.rdsel[p][3:0];
      model_step(0, sa);
      model_step(1, sb);
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between edges and asks the monitor to check the outputs
   // while no clock edge has occurred.
   task automatic reset_pulse();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 rst_probe = 1'b1;
      #1 rst_probe = 1'b0;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor / scoreboard.
   always @(negedge clk or posedge rst_probe) begin
      exp_t        e;
      logic [63:0] ad;
      logic        ab;
      if (rst_probe) begin
         vectors++;
         if (ifa.data_out !== '0 || ifa.busy_out !== '0) begin
            miscompares++;
            $display("FAIL reset_A: data_out=%h busy_out=%b, expected all zero",
                     ifa.data_out, ifa.busy_out);
         end
         vectors++;
         if (ifb.data_out !== '0 || ifb.busy_out !== '0) begin
            miscompares++;
            $display("FAIL reset_B: data_out=%h busy_out=%b, expected all zero",
                     ifb.data_out, ifb.busy_out);
         end
      end else begin
         while (q.size() > 0 && q[0].tag <= ecnt) begin
            e = q.pop_front();
            if (e.inst == 2'd0) begin
               ad = {32'h0, ifa.data_out[e.port*32 +: 32]};
               ab = ifa.busy_out[e.port];
            end else begin
               ad = ifb.data_out[e.port*64 +: 64];
               ab = ifb.busy_out[e.port];
            end
            vectors++;
            if (ad !== e.d || ab !== e.b) begin
               miscompares++;
               $display("FAIL read_%s_p%0d edge %0d: got data=%h busy=%b, expected data=%h busy=%b",
                        (e.inst == 2'd0) ? "A" : "B", e.port, e.tag, ad, ab, e.d, e.b);
            end
         end
      end
   end

   initial begin
      stim_t sa, sb;
      model_reset();
      sa = idle();
      sb = idle();
      ifa.write_en = 1'b0; ifa.write_sel = '0; ifa.data_in = '0; ifa.rsv_en = 1'b0;
      ifa.rsv_sel = '0; ifa.read_en = '0; ifa.read_sel = '0;
      ifb.write_en = 1'b0; ifb.write_sel = '0; ifb.data_in = '0; ifb.rsv_en = 1'b0;
      ifb.rsv_sel = '0; ifb.read_en = '0; ifb.read_sel = '0;
      #1 rst_probe = 1'b1;
      #1 rst_probe = 1'b0;
      #1 rst_n = 1'b1;

      // Reset: fill registers, reserve r5, pulse reset, read r5.
      for (int r = 1; r < 32; r++) begin
         sa = idle(); sb = idle();
         sa.we = 1'b1; sa.wsel = 5'(r); sa.din = 64'(r) * 64'h0101_0101 + 64'h10;
         if (r < 16) begin
            sb.we = 1'b1; sb.wsel = 5'(r); sb.din = 64'(r) * 64'h1111_0000_0101 + 64'h3;
         end
         cycle(sa, sb);
      end
      sa = idle(); sa.rsv = 1'b1; sa.rsel = 5'd5; sa.ren = 3'b011; sa.rdsel[0] = 5'd5; sa.rdsel[1] = 5'd9;
      sb = sa; sb.ren = 3'b111; sb.rdsel[2] = 5'd1;
      cycle(sa, sb);
      reset_pulse();
      sa = idle(); sa.ren = 3'b111; sa.rdsel[0] = 5'd5; sa.rdsel[1] = 5'd9;
      sb = sa; sb.rdsel[2] = 5'd1;
      cycle(sa, sb);

      // Forwarding: write r7 and read it on every port at the same edge.
      sa = idle(); sa.we = 1'b1; sa.wsel = 5'd7; sa.din = 64'hDEAD_BEEF; sa.ren = 3'b111;
      for (int p = 0; p < 3; p++) sa.rdsel[p] = 5'd7;
      sb = sa;
      cycle(sa, sb);
      sa = idle(); sa.ren = 3'b111;
      for (int p = 0; p < 3; p++) sa.rdsel[p] = 5'd7;
      sb = sa;
      cycle(sa, sb);

      // Zero register: A drops everything, B treats r0 as ordinary.
      sa = idle(); sa.we = 1'b1; sa.wsel = 5'd0; sa.din = 64'hFFFF_FFFF;
      sa.rsv = 1'b1; sa.rsel = 5'd0; sa.ren = 3'b001; sa.rdsel[0] = 5'd0;
      sb = sa;
      cycle(sa, sb);
      for (int i = 0; i < 2; i++) begin
         sa = idle(); sa.ren = 3'b001; sa.rdsel[0] = 5'd0;
         sb = sa;
         cycle(sa, sb);
      end

      // Scoreboard: reserve, clear by writeback, write+reserve together.
      sa = idle(); sa.rsv = 1'b1; sa.rsel = 5'd3; sa.ren = 3'b001; sa.rdsel[0] = 5'd3;
      sb = sa;
      cycle(sa, sb);
      sa = idle(); sa.ren = 3'b001; sa.rdsel[0] = 5'd3;
      sb = sa;
      cycle(sa, sb);
      sa = idle(); sa.we = 1'b1; sa.wsel = 5'd3; sa.din = 64'h12; sa.ren = 3'b001; sa.rdsel[0] = 5'd3;
      sb = sa;
      cycle(sa, sb);
      sa = idle(); sa.we = 1'b1; sa.wsel = 5'd3; sa.din = 64'h34; sa.rsv = 1'b1; sa.rsel = 5'd3;
      sa.ren = 3'b001; sa.rdsel[0] = 5'd3;
      sb = sa;
      cycle(sa, sb);

      // Read-enable hold on port 1 while port 0 keeps tracking r4.
      sa = idle(); sa.we = 1'b1; sa.wsel = 5'd4; sa.din = 64'hA5;
      sb = sa;
      cycle(sa, sb);
      sa = idle(); sa.ren = 3'b011; sa.rdsel[0] = 5'd4; sa.rdsel[1] = 5'd4;
      sb = sa;
      cycle(sa, sb);
      for (int i = 0; i < 3; i++) begin
         sa = idle(); sa.we = 1'b1; sa.wsel = 5'd4; sa.din = 64'h5A + 64'(i);
         sa.ren = 3'b001; sa.rdsel[0] = 5'd4; sa.rdsel[1] = 5'd9;
         sb = sa;
         cycle(sa, sb);
      end

      // Randomised traffic on both configurations.
      for (int i = 0; i < 10000; i++) begin
         cycle(rnd(32), rnd(16));
      end

      cycle(idle(), idle());
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
